// File: rtl/c2f_write_assembler.sv
// Assembles C2F register-window writes (253 addr, 254 LSW, 255 MSW) into {addr, data} FIFO entries.
// Optional macro C2F_AUTOINC_EN: post-increment the target address after every MSW push.
module c2f_write_assembler #(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                pcieClk_in,
    input  logic                pcieRst_in,
    input  logic                cpuWrValid_in,
    input  logic [7:0]          cpuWrReg_in,
    input  logic [31:0]         cpuWrData_in,
    output logic                cpuWrReady_out,
    output logic [ADDR_W-1:0]   c2fAddr_out,
    output logic [63:0]         c2fData_out,
    output logic                c2fValid_out,
    input  logic                c2fReady_in,
    output logic [DEPTH_LOG2:0] c2fCount_out
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = ADDR_W + 64;

    localparam logic [7:0] REG_ADDR = 8'd253;
    localparam logic [7:0] REG_LSW  = 8'd254;
    localparam logic [7:0] REG_MSW  = 8'd255;

    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
`ifdef C2F_AUTOINC_EN
    localparam logic [ADDR_W-1:0]     ADDR_ONE   = ADDR_W'(1);
`endif

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_addrReg;
    logic [31:0]           r_lswReg;
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_full;
    logic                  w_nonEmpty;
    logic                  w_wrAccept;
    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;

    // Ready depends only on the count register, so a full FIFO blocks every index alike.
    assign w_full         = (r_count == COUNT_FULL);
    assign w_nonEmpty     = (r_count != '0);
    assign cpuWrReady_out = !w_full;
    assign w_wrAccept     = cpuWrValid_in && !w_full;
    assign w_push         = w_wrAccept && (cpuWrReg_in == REG_MSW);
    assign w_pop          = w_nonEmpty && c2fReady_in;

    // Head is masked while empty so stale storage never leaks onto the outputs.
    assign w_head       = w_nonEmpty ? r_mem[r_rdPtr] : '0;
    assign c2fAddr_out  = w_head[ENTRY_W-1 -: ADDR_W];
    assign c2fData_out  = w_head[63:0];
    assign c2fValid_out = w_nonEmpty;
    assign c2fCount_out = r_count;

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRst_in) begin
            r_addrReg <= '0;
            r_lswReg  <= '0;
        end else if (w_wrAccept) begin
            if (cpuWrReg_in == REG_ADDR) begin
                r_addrReg <= cpuWrData_in[ADDR_W-1:0];
            end
`ifdef C2F_AUTOINC_EN
            else if (cpuWrReg_in == REG_MSW) begin
                r_addrReg <= r_addrReg + ADDR_ONE;
            end
`endif
            if (cpuWrReg_in == REG_LSW) begin
                r_lswReg <= cpuWrData_in;
            end
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in && w_push) begin
            r_mem[r_wrPtr] <= {r_addrReg, cpuWrData_in, r_lswReg};
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRst_in) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_c2f_write_assembler.sv
// Scoreboard bench for c2f_write_assembler: directed register writes push expected entries,
// a negedge monitor pops and compares every FIFO handshake. Honors C2F_AUTOINC_EN if defined.
module tb_c2f_write_assembler;
    localparam int ADDR_W     = 16;
    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;
    localparam int TIMEOUT    = 50;
`ifdef C2F_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic                pcieClk_in = 1'b0;
    logic                pcieRst_in;
    logic                cpuWrValid_in;
    logic [7:0]          cpuWrReg_in;
    logic [31:0]         cpuWrData_in;
    logic                cpuWrReady_out;
    logic [ADDR_W-1:0]   c2fAddr_out;
    logic [63:0]         c2fData_out;
    logic                c2fValid_out;
    logic                c2fReady_in;
    logic [DEPTH_LOG2:0] c2fCount_out;

    logic [ADDR_W+63:0]  expQ [$];
    logic [ADDR_W+63:0]  monExp;
    int                  checks   = 0;
    int                  failures = 0;

    c2f_write_assembler #(
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .pcieClk_in     (pcieClk_in),
        .pcieRst_in     (pcieRst_in),
        .cpuWrValid_in  (cpuWrValid_in),
        .cpuWrReg_in    (cpuWrReg_in),
        .cpuWrData_in   (cpuWrData_in),
        .cpuWrReady_out (cpuWrReady_out),
        .c2fAddr_out    (c2fAddr_out),
        .c2fData_out    (c2fData_out),
        .c2fValid_out   (c2fValid_out),
        .c2fReady_in    (c2fReady_in),
        .c2fCount_out   (c2fCount_out)
    );

    always #5 pcieClk_in = ~pcieClk_in;

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge pcieClk_in);
        #1;
    endtask

    task automatic expectEntry(input logic [ADDR_W-1:0] addr, input logic [63:0] data);
        expQ.push_back({addr, data});
    endtask

    task automatic applyStimulus(input logic [7:0] regIdx, input logic [31:0] data);
        int waited;
        waited        = 0;
        cpuWrValid_in = 1'b1;
        cpuWrReg_in   = regIdx;
        cpuWrData_in  = data;
        while (!cpuWrReady_out && waited < TIMEOUT) begin
            tick();
            waited++;
        end
        if (!cpuWrReady_out) begin
            checks++;
            failures++;
            $display("[TB] FAIL writeTimeout reg=0x%0h actual=ready_low required=handshake", regIdx);
        end else begin
            tick();
        end
        cpuWrValid_in = 1'b0;
    endtask

    task automatic drainFifo();
        int waited;
        waited      = 0;
        c2fReady_in = 1'b1;
        while (c2fCount_out != '0 && waited < TIMEOUT) begin
            tick();
            waited++;
        end
        checkOutput("drainCount", 80'(c2fCount_out), 80'd0);
        checkOutput("scoreboardEmpty", 80'(expQ.size()), 80'd0);
        c2fReady_in = 1'b0;
    endtask

    // Every head handshake is checked just before the edge that completes it.
    always @(negedge pcieClk_in) begin
        if (pcieRst_in === 1'b1 && c2fValid_out === 1'b1 && c2fReady_in === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedEntry actual=0x%0h required=none", {c2fAddr_out, c2fData_out});
            end else begin
                monExp = expQ.pop_front();
                checkOutput("headEntry", 80'({c2fAddr_out, c2fData_out}), 80'(monExp));
            end
        end
    end

    initial begin
        pcieRst_in    = 1'b0;
        cpuWrValid_in = 1'b0;
        cpuWrReg_in   = 8'h00;
        cpuWrData_in  = 32'h0;
        c2fReady_in   = 1'b0;
        repeat (2) tick();

        checkOutput("rstCount", 80'(c2fCount_out), 80'd0);
        checkOutput("rstValid", 80'(c2fValid_out), 80'd0);
        checkOutput("rstReady", 80'(cpuWrReady_out), 80'd1);
        checkOutput("rstAddr", 80'(c2fAddr_out), 80'd0);
        checkOutput("rstData", 80'(c2fData_out), 80'd0);
        pcieRst_in = 1'b1;
        tick();

        // Basic assembly; upper address bits must be dropped.
        applyStimulus(8'd253, 32'hABCD_0010);
        applyStimulus(8'd254, 32'hDEAD_BEEF);
        checkOutput("validBeforeMsw", 80'(c2fValid_out), 80'd0);
        applyStimulus(8'd255, 32'h0123_4567);
        expectEntry(16'h0010, 64'h0123_4567_DEAD_BEEF);
        checkOutput("validAfterMsw", 80'(c2fValid_out), 80'd1);
        checkOutput("countAfterMsw", 80'(c2fCount_out), 80'd1);
        drainFifo();

        // Address wrap with auto-increment, or repeat without it.
        applyStimulus(8'd253, 32'h0000_FFFF);
        applyStimulus(8'd254, 32'h0000_0001);
        applyStimulus(8'd255, 32'h0000_0002);
        expectEntry(16'hFFFF, 64'h0000_0002_0000_0001);
        applyStimulus(8'd254, 32'h0000_0003);
        applyStimulus(8'd255, 32'h0000_0004);
        expectEntry(AUTOINC ? 16'h0000 : 16'hFFFF, 64'h0000_0004_0000_0003);
        drainFifo();

        // Fill, stall, single pop releases the stalled write.
        applyStimulus(8'd253, 32'h0000_0100);
        applyStimulus(8'd254, 32'h0000_00A0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'd255, 32'h0000_00B0 + 32'(i));
            expectEntry(AUTOINC ? 16'(16'h0100 + i) : 16'h0100, {32'h0000_00B0 + 32'(i), 32'h0000_00A0});
        end
        checkOutput("fullReady", 80'(cpuWrReady_out), 80'd0);
        checkOutput("fullCount", 80'(c2fCount_out), 80'd8);
        cpuWrValid_in = 1'b1;
        cpuWrReg_in   = 8'd253;
        cpuWrData_in  = 32'h0000_0AAA;
        repeat (2) tick();
        cpuWrValid_in = 1'b0;
        cpuWrValid_in = 1'b1;
        cpuWrReg_in   = 8'd254;
        cpuWrData_in  = 32'h0000_0055;
        repeat (3) tick();
        checkOutput("stallReady", 80'(cpuWrReady_out), 80'd0);
        checkOutput("stallCount", 80'(c2fCount_out), 80'd8);
        c2fReady_in = 1'b1;
        tick();
        c2fReady_in = 1'b0;
        checkOutput("singlePopCount", 80'(c2fCount_out), 80'd7);
        checkOutput("singlePopReady", 80'(cpuWrReady_out), 80'd1);
        tick();
        cpuWrValid_in = 1'b0;
        checkOutput("stalledWriteNoPush", 80'(c2fCount_out), 80'd7);
        drainFifo();
        applyStimulus(8'd255, 32'h0000_00BB);
        expectEntry(AUTOINC ? 16'h0108 : 16'h0100, 64'h0000_00BB_0000_0055);
        drainFifo();

        // Back-to-back pushes with a consumer that is always ready.
        c2fReady_in = 1'b1;
        applyStimulus(8'd253, 32'h0000_0200);
        applyStimulus(8'd254, 32'h1111_1111);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'd255, 32'h0000_00C0 + 32'(i));
            expectEntry(AUTOINC ? 16'(16'h0200 + i) : 16'h0200, {32'h0000_00C0 + 32'(i), 32'h1111_1111});
            checkOutput("streamCount", 80'(c2fCount_out), 80'd1);
        end
        drainFifo();

        // Other indices handshake but touch nothing.
        c2fReady_in = 1'b1;
        applyStimulus(8'd253, 32'h0000_0300);
        applyStimulus(8'd254, 32'h2222_2222);
        applyStimulus(8'h10, 32'h0000_FFFF);
        applyStimulus(8'hFC, 32'h1234_5678);
        checkOutput("ignoredCount", 80'(c2fCount_out), 80'd0);
        checkOutput("ignoredValid", 80'(c2fValid_out), 80'd0);
        applyStimulus(8'd255, 32'h0000_0033);
        expectEntry(16'h0300, 64'h0000_0033_2222_2222);
        drainFifo();

        // Reset beats a simultaneous push and discards queued entries.
        applyStimulus(8'd253, 32'h0000_0400);
        applyStimulus(8'd254, 32'h0000_0044);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'd255, 32'h0000_00D0 + 32'(i));
        end
        checkOutput("preResetCount", 80'(c2fCount_out), 80'd3);
        pcieRst_in    = 1'b0;
        cpuWrValid_in = 1'b1;
        cpuWrReg_in   = 8'd255;
        cpuWrData_in  = 32'h0000_00EE;
        tick();
        cpuWrValid_in = 1'b0;
        pcieRst_in    = 1'b1;
        checkOutput("midRstCount", 80'(c2fCount_out), 80'd0);
        checkOutput("midRstValid", 80'(c2fValid_out), 80'd0);
        checkOutput("midRstReady", 80'(cpuWrReady_out), 80'd1);
        checkOutput("midRstData", 80'(c2fData_out), 80'd0);
        c2fReady_in = 1'b1;
        applyStimulus(8'd255, 32'h0000_0055);
        expectEntry(16'h0000, 64'h0000_0055_0000_0000);
        drainFifo();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c2f_write_assembler.md
# c2f_write_assembler

Downstream consumer of the CPU-to-FPGA register window (registers 253 = C2FADDR, 254 = C2FDATA_LSW, 255 = C2FDATA_MSW) in the pcie-dma application. It snoops the decoded register-write stream from the PCIe BAR, assembles each 64-bit data word plus its target address, and queues the results in an internal FIFO. Application logic drains the FIFO through a valid/ready interface.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the C2F target address; taken from `cpuWrData_in[ADDR_W-1:0]`, ADDR_W ≤ 32.
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (1..8).

Ports:
- `pcieClk_in`  in  1: sole clock.
- `pcieRst_in`  in  1: synchronous, active-low reset.
- `cpuWrValid_in`  in  1: a register write is presented.
- `cpuWrReg_in`  in  8: register index.
- `cpuWrData_in`  in  32: register write data.
- `cpuWrReady_out`  out  1: write accepted when valid && ready.
- `c2fAddr_out`  out  ADDR_W: FIFO head address.
- `c2fData_out`  out  64: FIFO head data, {MSW, LSW}.
- `c2fValid_out`  out  1: FIFO head valid.
- `c2fReady_in`  in  1: consumer pops head when valid && ready.
- `c2fCount_out`  out  DEPTH_LOG2+1: FIFO occupancy.

## Operation
- Holding registers: `addrReg` (ADDR_W), `lswReg` (32). Both reset to 0.
- Accepted write, reg 253: addrReg ← data[ADDR_W-1:0]; bits above ADDR_W ignored.
- Accepted write, reg 254: lswReg ← data.
- Accepted write, reg 255: push {addrReg, data, lswReg} into the FIFO; lswReg keeps its value, so an MSW-only write reuses the last LSW.
- Any other index: ignored, but still handshaken (ready rules unchanged).
- `cpuWrReady_out` = (count != 2^DEPTH_LOG2), combinational from the count register only. It applies to every index, so the writer need not decode.
- Writes to 253/254 while the FIFO is full are stalled like any other write. The holding registers are never updated without a handshake.
- FIFO: circular buffer, wr/rd pointers of DEPTH_LOG2 bits that wrap modulo depth; count register of DEPTH_LOG2+1 bits.
- Push and pop in the same cycle: count unchanged, both pointers advance. When full, push cannot occur (ready low) even if a pop occurs that cycle.
- Entries are never dropped or reordered.

## Timing
- Reset (`pcieRst_in`=0 at clock edge): pointers, count, addrReg, lswReg cleared. Outputs after reset: `c2fValid_out`=0, `c2fCount_out`=0, `cpuWrReady_out`=1, `c2fAddr_out`/`c2fData_out`=0. Pending entries are discarded.
- Reset asserted mid-stream takes priority over any simultaneous push or pop.
- Latency: an MSW accepted at edge N gives `c2fValid_out`=1 with the entry at head after edge N (visible in cycle N+1).
- A reg-253/254 write at edge N is used by an MSW accepted at edge N+1 (back-to-back writes are allowed).
- `c2fValid_out` = (count != 0). Head outputs are read combinationally from the storage at rdPtr and are stable while valid && !ready.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `C2F_AUTOINC_EN` defined: after each MSW push, addrReg ← addrReg + 1, wrapping modulo 2^ADDR_W. A reg-253 write in the same cycle cannot occur (one write per cycle).
- Undefined: addrReg changes only on reg-253 writes; consecutive MSW writes target the same address.

## Test plan
- Reset, then write 253=0x0010, 254=0xDEADBEEF, 255=0x01234567 → one entry: addr 0x0010, data 0x01234567_DEADBEEF, valid in the cycle after the MSW handshake, count=1.
- With `C2F_AUTOINC_EN`: 253=0xFFFF, then two LSW/MSW pairs → addrs 0xFFFF then 0x0000. Without the macro → both 0xFFFF.
- `c2fReady_in`=0; push 8 entries (DEPTH_LOG2=3) → `cpuWrReady_out`=0 and count=8. A 9th write (reg 254, 0x55) stalls and lswReg is unchanged. Raise ready for one cycle → a single pop, the stalled write is accepted, and the entries come out in order.
- Continuous MSW writes with `c2fReady_in`=1 → count stays at 1 with one push and one pop per cycle; data matches in sequence.
- Write to index 0x10 and 0xFC → no FIFO entry, holding registers unchanged, handshake completes.
- Reset asserted with 3 entries queued and a simultaneous MSW write → count=0, valid=0, addrReg=lswReg=0 on the next cycle.
